// File: rtl/arcade_ce_pkg.sv
// Shared types and helpers for the arcade_ce_gen fractional clock-enable generator.
// Optional ce counters are built when CEGEN_CNT_EN is defined.
package arcade_ce_pkg;

    localparam int unsigned CNT_W       = 16;
    localparam int unsigned RATIO_MAX_W = 32;
    localparam int unsigned MAX_CH      = 8;

    typedef struct packed {
        logic [RATIO_MAX_W-1:0] num;
        logic [RATIO_MAX_W-1:0] den;
    } ratio_t;

    // Extract channel idx (w bits per field) from zero-extended packed INIT vectors.
    function automatic ratio_t ratio_unpack(
        input logic [MAX_CH*RATIO_MAX_W-1:0] num_vec,
        input logic [MAX_CH*RATIO_MAX_W-1:0] den_vec,
        input int unsigned                   idx,
        input int unsigned                   w
    );
        ratio_t r;
        r = '0;
        for (int unsigned b = 0; b < w; b++) begin
            r.num[b] = num_vec[idx*w + b];
            r.den[b] = den_vec[idx*w + b];
        end
        return r;
    endfunction

endpackage

// File: rtl/arcade_ce_chan.sv
// One fractional clock-enable channel: num/den accumulator, ratio shadow with pending flag
// and, when CEGEN_CNT_EN is defined, a wrapping 16-bit ce counter.
import arcade_ce_pkg::*;

module arcade_ce_chan #(
    parameter int unsigned ACC_W = 8,
    parameter ratio_t      INIT  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pause_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [ACC_W-1:0] wr_num_i,
    input  logic [ACC_W-1:0] wr_den_i,
    output logic             ce_o,
    output logic             pend_d_o
`ifdef CEGEN_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_o
`endif
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] num_q, num_d;
    logic [ACC_W-1:0] den_q, den_d;
    logic [ACC_W-1:0] shn_q, shn_d;
    logic [ACC_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             ce_q, ce_d;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   sum_sub;
    logic             apply;

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, num_q};
        sum_sub = sum - {1'b0, den_q};
        acc_d   = acc_q;
        ce_d    = 1'b0;
        apply   = 1'b0;
        if (sync_i) begin
            acc_d = '0;
            apply = pend_q;
        end else if (den_q == '0) begin
            acc_d = '0;
            apply = pend_q;
        end else if (!pause_i) begin
            if (num_q >= den_q) begin
                ce_d  = 1'b1;
                acc_d = '0;
            end else if (sum >= {1'b0, den_q}) begin
                ce_d  = 1'b1;
                acc_d = sum_sub[ACC_W-1:0];
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
            apply = ce_d & pend_q;
        end

        num_d  = num_q;
        den_d  = den_q;
        pend_d = pend_q;
        shn_d  = shn_q;
        shd_d  = shd_q;
        if (apply) begin
            num_d  = shn_q;
            den_d  = shd_q;
            acc_d  = '0;
            pend_d = 1'b0;
        end
        // A write lands after any apply, so same-edge writes always remain pending.
        if (wr_i) begin
            shn_d  = wr_num_i;
            shd_d  = wr_den_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            num_q  <= INIT.num[ACC_W-1:0];
            den_q  <= INIT.den[ACC_W-1:0];
            shn_q  <= '0;
            shd_q  <= '0;
            pend_q <= 1'b0;
            ce_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            num_q  <= num_d;
            den_q  <= den_d;
            shn_q  <= shn_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            ce_q   <= ce_d;
        end
    end

    assign ce_o     = ce_q;
    assign pend_d_o = pend_d;

`ifdef CEGEN_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (ce_d) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/arcade_ce_gen.sv
// Multi-channel fractional clock-enable generator (num/den per channel, pause, sync, reprogramming).
// Define CEGEN_CNT_EN to build per-channel ce counters readable through cnt_o.
import arcade_ce_pkg::*;

module arcade_ce_gen #(
    parameter int unsigned              NUM_CH   = 3,
    parameter int unsigned              ACC_W    = 8,
    parameter logic [NUM_CH*ACC_W-1:0]  INIT_NUM = {8'd3, 8'd1, 8'd1},
    parameter logic [NUM_CH*ACC_W-1:0]  INIT_DEN = {8'd40, 8'd6, 8'd4},
    localparam int unsigned             CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              pause,
    input  logic              sync,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic              cfg_busy,
    output logic [NUM_CH-1:0] ce,
    output logic [CNT_W-1:0]  cnt_o
);

    localparam logic [MAX_CH*RATIO_MAX_W-1:0] NUM_EXT = (MAX_CH*RATIO_MAX_W)'(INIT_NUM);
    localparam logic [MAX_CH*RATIO_MAX_W-1:0] DEN_EXT = (MAX_CH*RATIO_MAX_W)'(INIT_DEN);

    logic [NUM_CH-1:0] pend_d;
    logic              busy_q;
`ifdef CEGEN_CNT_EN
    logic [CNT_W-1:0]  cnt_ch [NUM_CH];
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam ratio_t INIT_I = ratio_unpack(NUM_EXT, DEN_EXT, i, ACC_W);

        arcade_ce_chan #(
            .ACC_W (ACC_W),
            .INIT  (INIT_I)
        ) u_chan (
            .clk_i    (clk_sys),
            .rst_i    (reset),
            .pause_i  (pause),
            .sync_i   (sync),
            .wr_i     (cfg_wr && (cfg_ch == CH_W'(i))),
            .wr_num_i (cfg_num),
            .wr_den_i (cfg_den),
            .ce_o     (ce[i]),
            .pend_d_o (pend_d[i])
`ifdef CEGEN_CNT_EN
            ,
            .cnt_o    (cnt_ch[i])
`endif
        );
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |pend_d;
        end
    end

    assign cfg_busy = busy_q;

`ifdef CEGEN_CNT_EN
    always_comb begin
        cnt_o = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cnt_o = cnt_ch[i];
            end
        end
    end
`else
    assign cnt_o = '0;
`endif

endmodule

// File: tb/tb_arcade_ce_gen.sv
// Scoreboard bench for arcade_ce_gen: random stimulus, spec-level reference model, queued checks.
module tb_arcade_ce_gen;

    localparam int NCH = 3;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        pause   = 1'b0;
    logic        sync    = 1'b0;
    logic        cfg_wr  = 1'b0;
    logic [1:0]  cfg_ch  = '0;
    logic [7:0]  cfg_num = '0;
    logic [7:0]  cfg_den = '0;
    logic        cfg_busy;
    logic [2:0]  ce;
    logic [15:0] cnt_o;

    arcade_ce_gen dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .pause    (pause),
        .sync     (sync),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_num  (cfg_num),
        .cfg_den  (cfg_den),
        .cfg_busy (cfg_busy),
        .ce       (ce),
        .cnt_o    (cnt_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [2:0]  ce;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference state: the channel phase is the remainder of (elapsed edges * num) modulo den.
    int acc [NCH];
    int num [NCH];
    int den [NCH];
    int shn [NCH];
    int shd [NCH];
    bit pend[NCH];
    int cnt [NCH];

    function automatic void check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic model_reset();
        int in_n[NCH] = '{1, 1, 3};
        int in_d[NCH] = '{4, 6, 40};
        for (int i = 0; i < NCH; i++) begin
            acc[i] = 0; num[i] = in_n[i]; den[i] = in_d[i];
            shn[i] = 0; shd[i] = 0; pend[i] = 0; cnt[i] = 0;
        end
    endtask

    // Advance the model by one edge with the inputs currently driven; push what the DUT must show.
    task automatic model_step();
        exp_t e;
        e.ce = '0;
        for (int i = 0; i < NCH; i++) begin
            bit fire = 0;
            bit take = 0;
            if (sync) begin
                acc[i] = 0;
                take   = pend[i];
            end else if (den[i] == 0) begin
                acc[i] = 0;
                take   = pend[i];
            end else if (!pause) begin
                if (num[i] >= den[i]) begin
                    fire   = 1;
                    acc[i] = 0;
                end else begin
                    fire   = ((acc[i] + num[i]) / den[i]) > 0;
                    acc[i] = (acc[i] + num[i]) % den[i];
                end
                take = fire && pend[i];
            end
            if (take) begin
                num[i] = shn[i]; den[i] = shd[i]; acc[i] = 0; pend[i] = 0;
            end
            if (fire) cnt[i] = (cnt[i] + 1) % 65536;
            if (cfg_wr && int'(cfg_ch) == i) begin
                shn[i] = cfg_num; shd[i] = cfg_den; pend[i] = 1;
            end
            e.ce[i] = fire;
        end
        e.busy = pend[0] | pend[1] | pend[2];
`ifdef CEGEN_CNT_EN
        e.cnt = (int'(cfg_ch) < NCH) ? 16'(cnt[cfg_ch]) : 16'h0000;
`else
        e.cnt = 16'h0000;
`endif
        exp_q.push_back(e);
    endtask

    task automatic run(int edges, bit rnd);
        for (int k = 0; k < edges; k++) begin
            if (rnd) begin
                if ($urandom_range(0, 19) == 0) pause = ~pause;
                sync   = ($urandom_range(0, 39) == 0);
                cfg_wr = ($urandom_range(0, 11) == 0);
                cfg_ch = 2'($urandom_range(0, 3));
                cfg_num = 8'($urandom_range(0, 8));
                cfg_den = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 45));
            end else begin
                pause = 0; sync = 0; cfg_wr = 0;
                cfg_ch = 2'(k % 4);
            end
            model_step();
            @(posedge clk_sys);
            #2;
        end
    endtask

    // Monitor: one expectation per edge, sampled 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("ce", int'(ce), int'(e.ce));
                check("cfg_busy", int'(cfg_busy), int'(e.busy));
                check("cnt_o", int'(cnt_o), int'(e.cnt));
            end
        end
    end

    initial begin
        model_reset();
        #12;
        reset = 1'b0;
        check("reset_ce", int'(ce), 0);
        check("reset_busy", int'(cfg_busy), 0);
        check("reset_cnt", int'(cnt_o), 0);
        run(24, 0);
        run(1500, 1);

        // Mid-run asynchronous reset between edges.
        #3;
        pause = 0; sync = 0; cfg_wr = 0; cfg_ch = 2'd0;
        reset = 1'b1;
        #1;
        check("async_rst_ce", int'(ce), 0);
        check("async_rst_busy", int'(cfg_busy), 0);
        check("async_rst_cnt", int'(cnt_o), 0);
        @(posedge clk_sys);
        #2;
        reset = 1'b0;
        model_reset();
        run(24, 0);
        run(1500, 1);

        #10;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
